// File: rtl/muldiv_if.sv
// Issue/result bus between decode/EX and the multiply/divide sequencer.
//   start, op, a, b, mf_req, flush : issue side (driven by the pipeline)
//   hi, lo, busy, stall, done, div_zero : result/status side (driven by muldiv_ctrl)
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mf_req;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b, mf_req, flush,
        input  hi, lo, busy, stall, done, div_zero
    );

    modport slave (
        input  start, op, a, b, mf_req, flush,
        output hi, lo, busy, stall, done, div_zero
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer with HI/LO registers.
// One result bit per cycle: WIDTH CALC cycles, then one FIX cycle that applies
// signs and writes HI/LO (done pulses the cycle after FIX).
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : start/op(00 MULT,01 MULTU,10 DIV,11 DIVU)/a/b/mf_req/flush in,
//                  hi/lo/busy/stall/done/div_zero out (stall is combinational)
module muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
    logic [PW-1:0]    acc, acc_nxt;
    logic [WIDTH-1:0] opnd, opnd_nxt;
    logic [WIDTH-1:0] raw_a, raw_a_nxt;
    logic             is_div, is_div_nxt;
    logic             neg_q, neg_q_nxt;
    logic             neg_r, neg_r_nxt;
    logic             dz, dz_nxt;
    logic [WIDTH-1:0] hi_q, hi_nxt;
    logic [WIDTH-1:0] lo_q, lo_nxt;
    logic             done_q, done_nxt;
    logic             div_zero_q, div_zero_nxt;

    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sum, shifted, diff;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] quo, rem;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            opnd       <= '0;
            raw_a      <= '0;
            is_div     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dz         <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            acc        <= acc_nxt;
            opnd       <= opnd_nxt;
            raw_a      <= raw_a_nxt;
            is_div     <= is_div_nxt;
            neg_q      <= neg_q_nxt;
            neg_r      <= neg_r_nxt;
            dz         <= dz_nxt;
            hi_q       <= hi_nxt;
            lo_q       <= lo_nxt;
            done_q     <= done_nxt;
            div_zero_q <= div_zero_nxt;
        end
    end

    // Next-state and datapath step
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        acc_nxt      = acc;
        opnd_nxt     = opnd;
        raw_a_nxt    = raw_a;
        is_div_nxt   = is_div;
        neg_q_nxt    = neg_q;
        neg_r_nxt    = neg_r;
        dz_nxt       = dz;
        hi_nxt       = hi_q;
        lo_nxt       = lo_q;
        done_nxt     = 1'b0;
        div_zero_nxt = div_zero_q;
        sgn_a        = 1'b0;
        sgn_b        = 1'b0;
        mag_a        = '0;
        mag_b        = '0;
        sum          = '0;
        shifted      = '0;
        diff         = '0;
        prod         = '0;
        quo          = '0;
        rem          = '0;

        case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    // op[0]==0 selects the signed variants
                    sgn_a        = ~bus.op[0] & bus.a[WIDTH-1];
                    sgn_b        = ~bus.op[0] & bus.b[WIDTH-1];
                    mag_a        = sgn_a ? (WIDTH'(0) - bus.a) : bus.a;
                    mag_b        = sgn_b ? (WIDTH'(0) - bus.b) : bus.b;
                    acc_nxt      = {{WIDTH{1'b0}}, mag_a};
                    opnd_nxt     = mag_b;
                    raw_a_nxt    = bus.a;
                    is_div_nxt   = bus.op[1];
                    neg_q_nxt    = sgn_a ^ sgn_b;
                    neg_r_nxt    = sgn_a;
                    dz_nxt       = bus.op[1] && (bus.b == '0);
                    div_zero_nxt = 1'b0;
                    cnt_nxt      = '0;
                    state_nxt    = CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else begin
                    if (is_div) begin
                        // Restoring step: shift in next dividend bit, trial-subtract
                        shifted = acc[PW-1:WIDTH-1];
                        diff    = shifted - {1'b0, opnd};
                        if (!diff[WIDTH]) begin
                            acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        // Shift-add step: conditionally add, then shift right
                        sum     = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
                        acc_nxt = {sum, acc[WIDTH-1:1]};
                    end
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state_nxt = FIX;
                    end
                end
            end
            FIX: begin
                state_nxt = IDLE;
                if (!bus.flush) begin
                    if (!is_div) begin
                        prod   = neg_q ? (PW'(0) - acc) : acc;
                        hi_nxt = prod[PW-1:WIDTH];
                        lo_nxt = prod[WIDTH-1:0];
                    end else if (dz) begin
                        hi_nxt = raw_a;
                        lo_nxt = '1;
                    end else begin
                        quo    = acc[WIDTH-1:0];
                        rem    = acc[PW-1:WIDTH];
                        lo_nxt = neg_q ? (WIDTH'(0) - quo) : quo;
                        hi_nxt = neg_r ? (WIDTH'(0) - rem) : rem;
                    end
                    done_nxt     = 1'b1;
                    div_zero_nxt = dz;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state != IDLE);
    assign bus.stall    = (state != IDLE) && (bus.start || bus.mf_req);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (WIDTH=32).
module tb_muldiv_ctrl;
    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;
    localparam int LAT = 33;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE (or the done cycle) and wait for done; lat=-1 on timeout
    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat);
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        bus.start  = 1'b1;
        bus.mf_req = 1'b1;
        #1;
        checks += 6;
        if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_divzero got %b want 0", bus.div_zero); end
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall); end
        bus.start  = 1'b0;
        bus.mf_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_multu_max();
        int lat;
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checks += 3;
        if (lat != LAT) begin errors++; $display("FAIL multu_latency got %0d want %0d", lat, LAT); end
        if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", bus.hi); end
        if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", bus.lo); end
        tick();
        checks += 2;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", bus.done); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL multu_idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_signed();
        int lat;
        run_op(MULT, 32'hFFFF_FFFD, 32'd7, lat);
        checks += 3;
        if (lat != LAT) begin errors++; $display("FAIL mult_latency got %0d want %0d", lat, LAT); end
        if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
        if (bus.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", bus.lo); end
        tick();
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, lat);
        checks += 3;
        if (lat != LAT) begin errors++; $display("FAIL div_latency got %0d want %0d", lat, LAT); end
        if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", bus.lo); end
        if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", bus.hi); end
        tick();
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks += 2;
        if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL divmin_lo got %h want 80000000", bus.lo); end
        if (bus.hi !== 32'h0) begin errors++; $display("FAIL divmin_hi got %h want 0", bus.hi); end
        tick();
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(DIVU, 32'd100, 32'd0, lat);
        checks += 4;
        if (lat != LAT) begin errors++; $display("FAIL dz_latency got %0d want %0d", lat, LAT); end
        if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo got %h want ffffffff", bus.lo); end
        if (bus.hi !== 32'd100) begin errors++; $display("FAIL dz_hi got %h want 00000064", bus.hi); end
        if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", bus.div_zero); end
        tick();
        checks++;
        if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_sticky got %b want 1", bus.div_zero); end
        run_op(MULTU, 32'd2, 32'd3, lat);
        checks += 2;
        if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got %b want 0", bus.div_zero); end
        if (bus.lo !== 32'd6) begin errors++; $display("FAIL dz_next_lo got %h want 00000006", bus.lo); end
        tick();
    endtask

    task automatic test_stall();
        int  n_stall;
        logic seen;
        bus.op    = MULTU;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        // mf_req and a competing DIVU arrive while busy
        bus.mf_req = 1'b1;
        bus.start  = 1'b1;
        bus.op     = DIVU;
        bus.a      = 32'd9;
        bus.b      = 32'd3;
        n_stall = 0;
        seen    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.stall === 1'b1) n_stall++;
            if (i == 3) bus.start = 1'b0;
            tick();
        end
        checks += 5;
        if (seen !== 1'b1) begin errors++; $display("FAIL stall_done_seen got %b want 1", seen); end
        if (n_stall != 32) begin errors++; $display("FAIL stall_cycles got %0d want 32", n_stall); end
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall_done_cycle got %b want 0", bus.stall); end
        if (bus.lo !== 32'd30) begin errors++; $display("FAIL stall_lo got %h want 0000001e", bus.lo); end
        if (bus.hi !== 32'd0) begin errors++; $display("FAIL stall_hi got %h want 0", bus.hi); end
        bus.mf_req = 1'b0;
        tick();
        tick();
        checks += 2;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignored_start_busy got %b want 0", bus.busy); end
        if (bus.lo !== 32'd30) begin errors++; $display("FAIL ignored_start_lo got %h want 0000001e", bus.lo); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(MULTU, 32'd3, 32'd4, lat);
        checks++;
        if (bus.lo !== 32'd12) begin errors++; $display("FAIL b2b_first_lo got %h want 0000000c", bus.lo); end
        // Issue in the done cycle
        run_op(DIVU, 32'd1000, 32'd7, lat);
        checks += 3;
        if (lat != LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
        if (bus.lo !== 32'd142) begin errors++; $display("FAIL b2b_lo got %h want 0000008e", bus.lo); end
        if (bus.hi !== 32'd6) begin errors++; $display("FAIL b2b_hi got %h want 00000006", bus.hi); end
        tick();
    endtask

    task automatic test_flush_reset();
        int n_done;
        bus.op    = DIVU;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks += 4;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL flush_done got %b want 0", bus.done); end
        if (bus.hi !== 32'd6) begin errors++; $display("FAIL flush_hi got %h want 00000006", bus.hi); end
        if (bus.lo !== 32'd142) begin errors++; $display("FAIL flush_lo got %h want 0000008e", bus.lo); end
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        checks += 2;
        if (n_done != 0) begin errors++; $display("FAIL flush_no_done got %0d want 0", n_done); end
        if (bus.lo !== 32'd142) begin errors++; $display("FAIL flush_lo_held got %h want 0000008e", bus.lo); end
        // flush together with start in IDLE
        bus.op    = MULTU;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got %b want 0", bus.busy); end
        // asynchronous reset in the middle of CALC
        bus.op    = MULTU;
        bus.a     = 32'd7;
        bus.b     = 32'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b want 1", bus.busy); end
        bus.mf_req = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks += 5;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
        if (bus.hi !== 32'h0) begin errors++; $display("FAIL midreset_hi got %h want 0", bus.hi); end
        if (bus.lo !== 32'h0) begin errors++; $display("FAIL midreset_lo got %h want 0", bus.lo); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", bus.done); end
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL midreset_stall got %b want 0", bus.stall); end
        bus.mf_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.a      = '0;
        bus.b      = '0;
        bus.mf_req = 1'b0;
        bus.flush  = 1'b0;
        test_reset();
        test_multu_max();
        test_signed();
        test_div_zero();
        test_stall();
        test_back_to_back();
        test_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
